// File: rtl/aes_pkg.sv
// Shared AES constants, byte/column helpers and the control state type used by
// the iterative encryption core and its round datapath.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        READY,
        RUN,
        DONE
    } aes_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are row 0 in the MSB down to row 3 in the LSB.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic int nk_of(input int key_width);
        return key_width / 32;
    endfunction

    function automatic int nr_of(input int key_width);
        return key_width / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the
// last round) and AddRoundKey. Byte k of the block lives at row k%4, column k/4.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] next_state
);
    logic [127:0] sub_bytes;
    logic [127:0] shifted;
    logic [127:0] mixed;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            // Row r rotates left by r columns.
            localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
            assign sub_bytes[127-8*gi -: 8] = sbox(state[127-8*gi -: 8]);
            assign shifted[127-8*gi -: 8]   = sub_bytes[127-8*SRC -: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign mixed[127-32*gi -: 32] = mix_column(shifted[127-32*gi -: 32]);
        end
    endgenerate

    assign next_state = (final_round ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_encrypt_param.sv
// Iterative AES-128/192/256 encryptor: expands the key once into a word store,
// then runs one round per enabled clock for each accepted block.
module aes_encrypt_param
    import aes_pkg::*;
#(
    parameter int KEY_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 key_load,
    input  logic [KEY_WIDTH-1:0] key_in,
    output logic                 key_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         plaintext,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         ciphertext
);
    localparam int NK = nk_of(KEY_WIDTH);
    localparam int NR = nr_of(KEY_WIDTH);
    localparam int NW = 4 * (NR + 1);

    if (KEY_WIDTH != 128 && KEY_WIDTH != 192 && KEY_WIDTH != 256) begin : g_bad_key_width
        $error("aes_encrypt_param: KEY_WIDTH must be 128, 192 or 256");
    end

    aes_state_t   fsm_reg;
    logic [5:0]   widx_reg;
    logic [2:0]   kmod_reg;
    logic [3:0]   rcon_idx_reg;
    logic [3:0]   round_reg;
    logic [127:0] data_reg;
    logic [31:0]  w_mem [NW];

    logic [31:0]  prev_word;
    logic [31:0]  temp_word;
    logic [5:0]   rk_base;
    logic [127:0] round_key;
    logic [127:0] whiten_key;
    logic [127:0] round_out;
    logic         key_accept;
    logic         blk_accept;

    assign key_accept = key_load && (fsm_reg == IDLE || fsm_reg == READY || fsm_reg == DONE);
    assign in_ready   = (fsm_reg == READY) && en && !key_load;
    assign blk_accept = in_ready && in_valid;

    assign rk_base    = {round_reg, 2'b00};
    assign round_key  = {w_mem[rk_base], w_mem[rk_base + 6'd1],
                         w_mem[rk_base + 6'd2], w_mem[rk_base + 6'd3]};
    assign whiten_key = {w_mem[0], w_mem[1], w_mem[2], w_mem[3]};

    // kmod_reg tracks i mod NK so no divider is needed on the word index.
    always_comb begin
        prev_word = w_mem[widx_reg - 6'd1];
        temp_word = prev_word;
        if (kmod_reg == 3'd0) begin
            temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {RCON[rcon_idx_reg], 24'h000000};
        end else if (NK == 8 && kmod_reg == 3'd4) begin
            temp_word = sub_word(prev_word);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (key_accept) begin
                for (int i = 0; i < NK; i++) begin
                    w_mem[i] <= key_in[KEY_WIDTH-1-32*i -: 32];
                end
            end else if (fsm_reg == KEYEXP) begin
                w_mem[widx_reg] <= w_mem[widx_reg - 6'(NK)] ^ temp_word;
            end
        end
    end

    aes_round u_round (
        .state       (data_reg),
        .round_key   (round_key),
        .final_round (round_reg == 4'(NR)),
        .next_state  (round_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg      <= IDLE;
            widx_reg     <= '0;
            kmod_reg     <= '0;
            rcon_idx_reg <= '0;
            round_reg    <= '0;
            data_reg     <= '0;
            key_ready    <= 1'b0;
            out_valid    <= 1'b0;
            ciphertext   <= '0;
        end else if (en) begin
            case (fsm_reg)
                KEYEXP: begin
                    widx_reg <= widx_reg + 6'd1;
                    kmod_reg <= (kmod_reg == 3'(NK - 1)) ? 3'd0 : kmod_reg + 3'd1;
                    if (kmod_reg == 3'd0) begin
                        rcon_idx_reg <= rcon_idx_reg + 4'd1;
                    end
                    if (widx_reg == 6'(NW - 1)) begin
                        fsm_reg   <= READY;
                        key_ready <= 1'b1;
                    end
                end
                RUN: begin
                    data_reg <= round_out;
                    if (round_reg == 4'(NR)) begin
                        ciphertext <= round_out;
                        out_valid  <= 1'b1;
                        round_reg  <= '0;
                        fsm_reg    <= DONE;
                    end else begin
                        round_reg <= round_reg + 4'd1;
                    end
                end
                default: begin
                    // A new key always wins, dropping any ciphertext still held.
                    if (key_load) begin
                        fsm_reg      <= KEYEXP;
                        key_ready    <= 1'b0;
                        out_valid    <= 1'b0;
                        widx_reg     <= 6'(NK);
                        kmod_reg     <= '0;
                        rcon_idx_reg <= '0;
                    end else if (blk_accept) begin
                        data_reg  <= plaintext ^ whiten_key;
                        round_reg <= 4'd1;
                        fsm_reg   <= RUN;
                    end else if (fsm_reg == DONE && out_ready) begin
                        out_valid <= 1'b0;
                        fsm_reg   <= READY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_param.sv
// Scoreboard bench for aes_encrypt_param: known-answer and random blocks are
// checked against a GF(2^8)-arithmetic AES model; a monitor pops and compares.
module tb_aes_encrypt_param;
    parameter int KW = 128;
    localparam int NK = KW / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          key_load = 1'b0;
    logic [KW-1:0] key_in = '0;
    logic          key_ready;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  plaintext = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [127:0]  ciphertext;

    always #5 clk = ~clk;

    aes_encrypt_param #(.KEY_WIDTH(KW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .key_load   (key_load),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    int           n_checks = 0;
    int           n_fail = 0;
    int           n_out = 0;
    int           bp_mode = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   sb[256];
    logic [KW-1:0] cur_key;
    logic [KW-1:0] tmp_key;
    logic [127:0]  tmp_pt;
    logic [127:0]  kat_ct;
    int            lat;

    task automatic check_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic check_word(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [KW-1:0] key, input logic [127:0] pt);
        logic [31:0]  w[60];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s[16];
        logic [7:0]   u[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < NK; i++) w[i] = key[KW-1-32*i -: 32];
        for (int i = NK; i < NW; i++) begin
            t = w[i-1];
            if (i % NK == 0) begin
                t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (NK > 6 && i % NK == 4) begin
                t = sub_w(t);
            end
            w[i] = w[i-NK] ^ t;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
        for (int r = 0; r <= NR; r++) begin
            if (r > 0) begin
                for (int k = 0; k < 16; k++) u[k] = sb[s[k]];
                for (int row = 0; row < 4; row++)
                    for (int col = 0; col < 4; col++)
                        s[row+4*col] = u[row+4*((col+row)%4)];
                if (r < NR) begin
                    for (int col = 0; col < 4; col++) begin
                        a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                        s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
                end
            end
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    s[row+4*col] = s[row+4*col] ^ w[4*r+col][31-8*row -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    // ---------------- stimulus helpers (entered at posedge+1) ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [KW-1:0] k);
        int n;
        n = 0;
        key_in = k;
        key_load = 1'b1;
        cycle();
        key_load = 1'b0;
        while (!key_ready && n < 500) begin
            cycle();
            n++;
        end
        check_int("key_expand_latency", n, NW - NK);
        cur_key = k;
        $display("key loaded after %0d cycles", n);
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] e, input bit push);
        int n;
        n = 0;
        in_valid = 1'b1;
        plaintext = pt;
        forever begin
            @(negedge clk);
            if (in_ready || n >= 500) break;
            n++;
        end
        if (!in_ready) begin
            check_bit("in_ready_timeout", in_ready, 1'b1);
        end else if (push) begin
            exp_q.push_back(e);
        end
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < 500) begin
            cycle();
            n++;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            cycle();
            n++;
        end
        check_int("scoreboard_drained", exp_q.size(), 0);
    endtask

    // ---------------- output-side processes ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic         hold_prev;
        logic [127:0] hold_ct;
        logic [127:0] e;
        hold_prev = 1'b0;
        hold_ct = '0;
        forever begin
            @(negedge clk);
            if (hold_prev) begin
                check_bit("hold_out_valid", out_valid, 1'b1);
                check_word("hold_ciphertext", ciphertext, hold_ct);
            end
            if (out_valid) check_bit("in_ready_while_output", in_ready, 1'b0);
            if (out_valid && out_ready && en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, want no output", ciphertext);
                end else begin
                    e = exp_q.pop_front();
                    check_word("ciphertext", ciphertext, e);
                    $display("block %0d: ciphertext %h expected %h", n_out, ciphertext, e);
                end
                n_out++;
            end
            hold_prev = out_valid && !(out_ready && en) && reset_n;
            hold_ct = ciphertext;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        build_sbox();
        #1;
        check_bit("reset_key_ready", key_ready, 1'b0);
        check_bit("reset_in_ready", in_ready, 1'b0);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_word("reset_ciphertext", ciphertext, 128'h0);
        repeat (2) cycle();
        reset_n = 1'b1;
        en = 1'b1;
        cycle();

        // Known-answer vector for this key width, with latency checks.
        tmp_key = '0;
        for (int i = 0; i < KW / 8; i++) tmp_key[KW-1-8*i -: 8] = 8'(i);
        case (KW)
            128:     kat_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            192:     kat_ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            default: kat_ct = 128'h8ea2b7ca516745bfeafc49904b496089;
        endcase
        load_key(tmp_key);
        send(FIPS_PT, kat_ct, 1'b1);
        wait_out_valid(lat);
        check_int("encrypt_latency", lat, NR);
        wait_drain();

        // Second key: its known answer, then key reuse with the FIPS block.
        tmp_key = '0;
        tmp_key[KW-1 -: 128] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        load_key(tmp_key);
        tmp_pt = 128'h3243f6a8885a308d313198a2e0370734;
        send(tmp_pt, (KW == 128) ? 128'h3925841d02dc09fbdc118597196a0b32 : model_encrypt(cur_key, tmp_pt), 1'b1);
        send(FIPS_PT, model_encrypt(cur_key, FIPS_PT), 1'b1);
        wait_drain();

        // Backpressure: hold out_ready low for 20 cycles once the result is up.
        bp_mode = 2;
        cycle();
        tmp_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(tmp_pt, model_encrypt(cur_key, tmp_pt), 1'b1);
        wait_out_valid(lat);
        check_int("latency_before_hold", lat, NR);
        repeat (20) cycle();
        check_bit("held_out_valid_after_20", out_valid, 1'b1);
        bp_mode = 0;
        wait_drain();

        // Clock enable dropped for 5 cycles mid-run stretches latency by 5.
        tmp_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(tmp_pt, model_encrypt(cur_key, tmp_pt), 1'b1);
        lat = 0;
        repeat (3) begin cycle(); lat++; end
        en = 1'b0;
        repeat (5) begin cycle(); lat++; end
        en = 1'b1;
        while (!out_valid && lat < 500) begin cycle(); lat++; end
        check_int("latency_with_en_gap", lat, NR + 5);
        wait_drain();

        // key_load during RUN is ignored.
        tmp_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(tmp_pt, model_encrypt(cur_key, tmp_pt), 1'b1);
        cycle();
        key_in = ~cur_key;
        key_load = 1'b1;
        cycle();
        key_load = 1'b0;
        wait_drain();
        check_bit("key_ready_after_run_load", key_ready, 1'b1);
        tmp_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(tmp_pt, model_encrypt(cur_key, tmp_pt), 1'b1);
        wait_drain();

        // key_load and in_valid together in READY: the key wins.
        for (int i = 0; i < NK; i++) tmp_key[32*i +: 32] = $urandom();
        key_in = tmp_key;
        key_load = 1'b1;
        in_valid = 1'b1;
        plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        check_bit("in_ready_under_key_load", in_ready, 1'b0);
        cycle();
        key_load = 1'b0;
        in_valid = 1'b0;
        check_bit("key_ready_cleared_on_load", key_ready, 1'b0);
        lat = 0;
        while (!key_ready && lat < 500) begin cycle(); lat++; end
        check_int("key_expand_latency_2", lat, NW - NK);
        cur_key = tmp_key;
        tmp_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(tmp_pt, model_encrypt(cur_key, tmp_pt), 1'b1);
        wait_drain();

        // Random keys and blocks with random output backpressure.
        for (int kk = 0; kk < 3; kk++) begin
            for (int i = 0; i < NK; i++) tmp_key[32*i +: 32] = $urandom();
            load_key(tmp_key);
            bp_mode = 1;
            for (int b = 0; b < 6; b++) begin
                tmp_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
                send(tmp_pt, model_encrypt(cur_key, tmp_pt), 1'b1);
            end
            bp_mode = 0;
            wait_drain();
        end

        // Asynchronous reset mid-run discards the block and the key.
        tmp_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(tmp_pt, 128'h0, 1'b0);
        repeat (3) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check_bit("async_reset_out_valid", out_valid, 1'b0);
        check_bit("async_reset_key_ready", key_ready, 1'b0);
        check_bit("async_reset_in_ready", in_ready, 1'b0);
        cycle();
        reset_n = 1'b1;
        repeat (NR + 5) cycle();
        check_bit("post_reset_key_ready", key_ready, 1'b0);
        check_bit("post_reset_out_valid", out_valid, 1'b0);
        load_key(tmp_key);
        tmp_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(tmp_pt, model_encrypt(cur_key, tmp_pt), 1'b1);
        wait_drain();

        repeat (3) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
